// File: rtl/decode_stage_pkg.sv
// Shared constants, FSM encoding and decoded-operand bundle for the RV32I decode stage.
package decode_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rs1_value;
        logic [XLEN-1:0]       mux_result;
        logic                  illegal;
    } decode_t;

    // I-type immediate; bits [11:5] keep instr[31:25] so shift-immediates expose funct7.
    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{(XLEN-12){instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32 x XLEN register file: two combinational read ports, one synchronous write port, x0 fixed at zero.
module regfile
    import decode_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    output logic [XLEN-1:0]       rd_data_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [XLEN-1:0]       rd_data_b,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]       wr_data
);

    logic [XLEN-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : mem_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : mem_q[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry valid/ready buffer that decodes R/I-type ALU instructions
// and reads operands from the register file, with writeback-to-read bypass.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid_in,
    input  logic [31:0]           instr_in,
    output logic                  instr_ready_out,
    output logic                  ex_valid_out,
    input  logic                  ex_ready_in,
    output logic [6:0]            opcode_out,
    output logic [2:0]            funct3_out,
    output logic [6:0]            funct7_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [XLEN-1:0]       rs1_value_out,
    output logic [XLEN-1:0]       mux_result_out,
    output logic                  illegal_out,
    input  logic                  wb_en_in,
    input  logic [REG_ADDR_W-1:0] wb_rd_in,
    input  logic [XLEN-1:0]       wb_data_in
);

    state_e  state_q, state_d;
    decode_t dec_q, dec_d;
    decode_t decoded;

    logic                  transfer;
    logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0]       rf_rs1, rf_rs2;
    logic [XLEN-1:0]       rs1_fwd, rs2_fwd;

    assign rs1_addr = instr_in[19:15];
    assign rs2_addr = instr_in[24:20];

    regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs1_addr),
        .rd_data_a (rf_rs1),
        .rd_addr_b (rs2_addr),
        .rd_data_b (rf_rs2),
        .wr_en     (wb_en_in),
        .wr_addr   (wb_rd_in),
        .wr_data   (wb_data_in)
    );

    // A same-cycle writeback wins over the stored value, since the array only updates at the edge.
    assign rs1_fwd = (wb_en_in && (wb_rd_in != '0) && (wb_rd_in == rs1_addr)) ? wb_data_in : rf_rs1;
    assign rs2_fwd = (wb_en_in && (wb_rd_in != '0) && (wb_rd_in == rs2_addr)) ? wb_data_in : rf_rs2;

    assign ex_valid_out    = (state_q == ST_FULL);
    assign instr_ready_out = !ex_valid_out || ex_ready_in;
    assign transfer        = instr_valid_in && instr_ready_out;

    always_comb begin
        decoded         = '0;
        decoded.opcode  = instr_in[6:0];
        decoded.funct3  = instr_in[14:12];
        decoded.funct7  = instr_in[31:25];
        decoded.rd      = instr_in[11:7];
        decoded.illegal = 1'b1;
        case (instr_in[6:0])
            OP_REG: begin
                decoded.illegal    = 1'b0;
                decoded.rs1_value  = rs1_fwd;
                decoded.mux_result = rs2_fwd;
            end
            OP_IMM: begin
                decoded.illegal    = 1'b0;
                decoded.rs1_value  = rs1_fwd;
                decoded.mux_result = imm_i(instr_in);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        if (transfer) begin
            state_d = ST_FULL;
            dec_d   = decoded;
        end else if (ex_ready_in) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            dec_q   <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
        end
    end

    assign opcode_out     = dec_q.opcode;
    assign funct3_out     = dec_q.funct3;
    assign funct7_out     = dec_q.funct7;
    assign rd_out         = dec_q.rd;
    assign rs1_value_out  = dec_q.rs1_value;
    assign mux_result_out = dec_q.mux_result;
    assign illegal_out    = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid_in;
    logic [31:0] instr_in;
    logic        instr_ready_out;
    logic        ex_valid_out;
    logic        ex_ready_in;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic [4:0]  rd_out;
    logic [31:0] rs1_value_out;
    logic [31:0] mux_result_out;
    logic        illegal_out;
    logic        wb_en_in;
    logic [4:0]  wb_rd_in;
    logic [31:0] wb_data_in;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid_in  (instr_valid_in),
        .instr_in        (instr_in),
        .instr_ready_out (instr_ready_out),
        .ex_valid_out    (ex_valid_out),
        .ex_ready_in     (ex_ready_in),
        .opcode_out      (opcode_out),
        .funct3_out      (funct3_out),
        .funct7_out      (funct7_out),
        .rd_out          (rd_out),
        .rs1_value_out   (rs1_value_out),
        .mux_result_out  (mux_result_out),
        .illegal_out     (illegal_out),
        .wb_en_in        (wb_en_in),
        .wb_rd_in        (wb_rd_in),
        .wb_data_in      (wb_data_in)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    bit          m_init  = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_show  = 1'b0;
    logic [31:0] ref_rf [32];
    logic [31:0] e_op, e_f3, e_f7, e_rd, e_rs1, e_b, e_ill;

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit we,
                                               input logic [4:0] wrd, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wrd == a) return wd;
        return ref_rf[a];
    endfunction

    task automatic model_accept(input logic [31:0] ins, input bit we,
                                input logic [4:0] wrd, input logic [31:0] wd);
        logic [6:0]  op;
        logic [11:0] imm12;
        int          imm;
        op    = ins[6:0];
        imm12 = ins[31:20];
        imm   = $signed(imm12);
        e_op  = 32'(op);
        e_f3  = 32'(ins[14:12]);
        e_f7  = 32'(ins[31:25]);
        e_rd  = 32'(ins[11:7]);
        if (op == 7'h33) begin
            e_ill = 0;
            e_rs1 = model_read(ins[19:15], we, wrd, wd);
            e_b   = model_read(ins[24:20], we, wrd, wd);
        end else if (op == 7'h13) begin
            e_ill = 0;
            e_rs1 = model_read(ins[19:15], we, wrd, wd);
            e_b   = 32'(imm);
        end else begin
            e_ill = 1;
            e_rs1 = 0;
            e_b   = 0;
        end
    endtask

    task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit we,
                        input logic [4:0] wrd, input logic [31:0] wd, input bit r);
        bit xfer;
        @(negedge clk);
        rst            = r;
        instr_valid_in = v;
        instr_in       = ins;
        ex_ready_in    = rdy;
        wb_en_in       = we;
        wb_rd_in       = wrd;
        wb_data_in     = wd;
        #1;
        if (m_init) check("ready", 32'(instr_ready_out), 32'(!m_valid || rdy));
        xfer = v && (!m_valid || rdy);
        if (r) begin
            m_init  = 1'b1;
            m_valid = 1'b0;
            m_show  = 1'b1;
            {e_op, e_f3, e_f7, e_rd, e_rs1, e_b, e_ill} = '0;
            for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
            $display("reset");
        end else if (m_init) begin
            if (xfer) begin
                model_accept(ins, we, wrd, wd);
                m_valid = 1'b1;
                $display("xfer instr=%08h rs1=%08h b=%08h illegal=%0d", ins, e_rs1, e_b, e_ill);
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            m_show = m_valid;
            if (we && wrd != 0) ref_rf[wrd] = wd;
        end
        @(posedge clk);
        #1;
        if (m_init) begin
            check("ex_valid", 32'(ex_valid_out), 32'(m_valid));
            if (m_show) begin
                check("opcode",  32'(opcode_out),  e_op);
                check("funct3",  32'(funct3_out),  e_f3);
                check("funct7",  32'(funct7_out),  e_f7);
                check("rd",      32'(rd_out),      e_rd);
                check("rs1_val", rs1_value_out,    e_rs1);
                check("mux_res", mux_result_out,   e_b);
                check("illegal", 32'(illegal_out), e_ill);
            end
        end
    endtask

    initial begin
        logic [31:0] r32, ins;
        logic [6:0]  op;
        rst = 1'b1; instr_valid_in = 1'b0; instr_in = '0; ex_ready_in = 1'b0;
        wb_en_in = 1'b0; wb_rd_in = '0; wb_data_in = '0;

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("rst_valid", 32'(ex_valid_out), 0);
        check("rst_ready", 32'(instr_ready_out), 1);

        // addi x1,x0,5
        step(1, 32'h00500093, 1, 0, 0, 0, 0);
        check("t35_valid", 32'(ex_valid_out), 1);
        check("t35_op",    32'(opcode_out), 32'h13);
        check("t35_f3",    32'(funct3_out), 0);
        check("t35_rd",    32'(rd_out), 1);
        check("t35_rs1",   rs1_value_out, 0);
        check("t35_b",     mux_result_out, 32'h5);

        // x1=5, x2=-16, then add x3,x1,x2
        step(0, 0, 1, 1, 1, 32'h5, 0);
        step(0, 0, 1, 1, 2, 32'hFFFFFFF0, 0);
        step(1, 32'h002081B3, 1, 0, 0, 0, 0);
        check("t36_rs1", rs1_value_out, 32'h5);
        check("t36_b",   mux_result_out, 32'hFFFFFFF0);
        check("t36_f7",  32'(funct7_out), 0);
        check("t36_rd",  32'(rd_out), 3);

        // srai x4,x1,3
        step(1, 32'h4030D213, 1, 0, 0, 0, 0);
        check("t37_f3", 32'(funct3_out), 5);
        check("t37_f7", 32'(funct7_out), 32'h20);
        check("t37_b",  mux_result_out, 32'h403);

        // stall three cycles with a pending addi x5,x0,10
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00A00293, 0, 0, 0, 0, 0);
            check("t38_ready", 32'(instr_ready_out), 0);
            check("t38_hold",  mux_result_out, 32'h403);
            check("t38_f3",    32'(funct3_out), 5);
        end
        step(1, 32'h00A00293, 1, 0, 0, 0, 0);
        check("t38_rd", 32'(rd_out), 5);
        check("t38_b",  mux_result_out, 32'hA);

        // bypass into addi x6,x5,0; x0 write discarded
        step(1, 32'h00028313, 1, 1, 5, 32'h1234, 0);
        check("t39_byp", rs1_value_out, 32'h1234);
        step(0, 0, 1, 1, 0, 32'hFFFF, 0);
        step(1, 32'h000003B3, 1, 0, 0, 0, 0);
        check("t39_x0_a", rs1_value_out, 0);
        check("t39_x0_b", mux_result_out, 0);

        // reset mid-stall with a simultaneous writeback
        step(1, 32'h00A00293, 1, 0, 0, 0, 0);
        step(1, 32'h00A00293, 0, 0, 0, 0, 0);
        step(1, 32'h00A00293, 0, 1, 1, 32'd99, 1);
        check("t40_valid", 32'(ex_valid_out), 0);
        check("t40_ready", 32'(instr_ready_out), 1);
        step(1, 32'h00008093, 1, 0, 0, 0, 0);
        check("t40_x1", rs1_value_out, 0);
        step(1, 32'h0000007F, 1, 0, 0, 0, 0);
        check("t40_ill",  32'(illegal_out), 1);
        check("t40_rs1",  rs1_value_out, 0);
        check("t40_b",    mux_result_out, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       op = 7'h33;
                1, 3:    op = 7'h13;
                default: op = 7'($urandom());
            endcase
            r32 = $urandom();
            ins = {r32[31:7], op};
            ins[19:15] = 5'($urandom_range(0, 7));
            if (op == 7'h33) ins[24:20] = 5'($urandom_range(0, 7));
            step(bit'($urandom_range(0, 1)), ins, bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                 $urandom_range(0, 63) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 instr_valid_in  input  1  fetch presents an instruction.
REQ-005 instr_in  input  32  RV32I instruction word.
REQ-006 instr_ready_out  output  1  block accepts instr_in this cycle.
REQ-007 ex_valid_out  output  1  decoded operands valid toward the ALU.
REQ-008 ex_ready_in  input  1  ALU/execute consumes the outputs this cycle.
REQ-009 opcode_out  output  7  instr[6:0].
REQ-010 funct3_out  output  3  instr[14:12].
REQ-011 funct7_out  output  7  instr[31:25].
REQ-012 rd_out  output  5  instr[11:7].
REQ-013 rs1_value_out  output  32  register value of instr[19:15].
REQ-014 mux_result_out  output  32  operand B: rs2 value for R-type, sign-extended instr[31:20] for I-type.
REQ-015 illegal_out  output  1  opcode is neither 0110011 nor 0010011.
REQ-016 wb_en_in  input  1  register write strobe from writeback.
REQ-017 wb_rd_in  input  5  write destination.
REQ-018 wb_data_in  input  32  write data.

Function
REQ-019 The block SHALL be a two-state FSM: EMPTY (ex_valid_out=0) and FULL (ex_valid_out=1).
REQ-020 instr_ready_out SHALL equal (!ex_valid_out || ex_ready_in), combinationally.
REQ-021 A transfer SHALL occur when instr_valid_in && instr_ready_out; decoded outputs SHALL appear on the next rising edge (latency 1).
REQ-022 Transitions: EMPTY->FULL on transfer; FULL->FULL on transfer with ex_ready_in=1; FULL->EMPTY on ex_ready_in=1 without transfer; otherwise hold.
REQ-023 While FULL and ex_ready_in=0, all outputs SHALL hold bit-stable.
REQ-024 Register file: 32 x 32 bits; x0 SHALL read 0; writes to x0 SHALL be discarded.
REQ-025 Writes SHALL commit on the rising edge when wb_en_in=1, independent of handshake state.
REQ-026 Bypass: if wb_en_in=1, wb_rd_in!=0 and wb_rd_in equals a source register of the instruction being accepted, wb_data_in SHALL be used in place of the stored value.
REQ-027 I-type immediate SHALL be sign-extended from instr[31]; bits [11:5] of mux_result_out SHALL equal instr[31:25], so shift-immediates carry their funct7 field there.
REQ-028 For an illegal opcode, the block SHALL still complete the handshake with illegal_out=1, rs1_value_out=0 and mux_result_out=0.
REQ-029 Operands already captured SHALL NOT be updated by later writebacks; there is no hazard detection beyond REQ-026.

Reset
REQ-030 When rst=1 at a clock edge, the FSM SHALL enter EMPTY and all registered outputs SHALL become 0.
REQ-031 Reset SHALL clear every register-file entry to 0.
REQ-032 Reset SHALL take priority over a simultaneous transfer or writeback, including mid-stall.

Structure
REQ-033 A shared package SHALL hold the opcode constants (OP_REG=7'b0110011, OP_IMM=7'b0010011), field widths (XLEN=32, REG_ADDR_W=5) and the FSM state encoding.
REQ-034 The register file SHALL be a sub-module named regfile, with two combinational read ports and one synchronous write port.

Verification
REQ-035 Write 0x00500093 (addi x1,x0,5) with ex_ready_in=1 -> next cycle ex_valid_out=1, opcode 0010011, funct3 000, rd 1, rs1_value 0, mux_result 0x00000005.
REQ-036 Write x1=5 and x2=0xFFFFFFF0, then issue 0x002081B3 (add x3,x1,x2) -> rs1_value 0x00000005, mux_result 0xFFFFFFF0, funct7 0000000, rd 3.
REQ-037 Issue 0x4030D213 (srai x4,x1,3) -> funct3 101, funct7 0100000, mux_result 0x00000403.
REQ-038 While FULL, hold ex_ready_in=0 for 3 cycles with instr_valid_in=1 -> instr_ready_out=0 and outputs unchanged; raise ex_ready_in -> the new instruction appears on the next cycle.
REQ-039 In the same cycle as accepting an instruction that reads x5, drive wb_en_in=1, wb_rd_in=5, wb_data_in=0x1234 -> rs1_value 0x00001234. A write of 0xFFFF to x0 -> subsequent reads of x0 return 0.
REQ-040 Assert rst during a stall -> next cycle ex_valid_out=0 and instr_ready_out=1; reads of x1 return 0; opcode 0x7F -> illegal_out=1.
